// File: rtl/toi2s_pkg.sv
// Shared constants for the I2S transmit serializer: default sample width,
// I2S frame geometry and bit-clock divider sizing.
package toi2s_pkg;

  localparam int DW_DEFAULT       = 16;
  localparam int BCK_HALF_DEFAULT = 2;
  localparam int SLOT_BITS        = 32;
  localparam int FRAME_BITS       = 64;
  localparam int SLOT_W           = 6;
  localparam int DIV_W            = 8;

  // Word select is high for the right-channel slot, starting one bck before its MSB.
  function automatic logic ws_for_slot(input logic [SLOT_W-1:0] s);
    return (s >= SLOT_W'(SLOT_BITS - 1)) && (s <= SLOT_W'(FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: toggles bck every BCK_HALF clk cycles while enabled and
// flags the clk edges on which bck rises or falls.
module i2s_bck_gen
  import toi2s_pkg::*;
#(
  parameter int BCK_HALF = BCK_HALF_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bck,
  output logic rise,
  output logic fall
);

  logic [DIV_W-1:0] div_cnt;
  logic             half_done;

  assign half_done = enable && !reset && (div_cnt == DIV_W'(BCK_HALF - 1));
  assign rise      = half_done && !bck;
  assign fall      = half_done && bck;

  // Half-period counter; stopping clears it so a restart begins with a full low half.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (div_cnt == DIV_W'(BCK_HALF - 1)) begin
      div_cnt <= '0;
      bck     <= ~bck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) transmit serializer: one-deep holding register for PCM pairs,
// 64-bit frame shift register, slot counter and ws/d0 generation on bck falls.
module i2s_tx_serializer
  import toi2s_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int BCK_HALF = BCK_HALF_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] left_in,
  input  logic [DW-1:0] right_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          i2s_bck,
  output logic          i2s_ws,
  output logic          i2s_d0,
  output logic          underrun
);

  logic                  bck_fall;
  logic                  unused_bck_rise;   // outputs only change on falls
  logic [SLOT_W-1:0]     slot;
  logic [SLOT_W-1:0]     slot_nxt;
  logic                  frame_start;
  logic                  hold_full;
  logic signed [DW-1:0]  hold_l;
  logic signed [DW-1:0]  hold_r;
  logic [FRAME_BITS-1:0] frame_sh;
  logic [FRAME_BITS-1:0] frame_src;

  // Place each channel MSB-first at the top of its 32-bit slot, zero padded.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DW-1:0] l,
                                                       input logic [DW-1:0] r);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: DW] = l;
    f[SLOT_BITS-1 -: DW]  = r;
    return f;
  endfunction

  i2s_bck_gen #(
    .BCK_HALF(BCK_HALF)
  ) u_bck_gen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bck   (i2s_bck),
    .rise  (unused_bck_rise),
    .fall  (bck_fall)
  );

  assign slot_nxt     = slot + SLOT_W'(1);
  assign frame_start  = bck_fall && (slot == SLOT_W'(FRAME_BITS - 1));
  assign frame_src    = hold_full ? pack_frame(hold_l, hold_r) : '0;
  assign sample_ready = !hold_full;

  // Holding register: drained at each frame boundary, filled by the valid/ready handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (frame_start && hold_full) begin
      hold_full <= 1'b0;
    end else if (sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_l    <= left_in;
      hold_r    <= right_in;
    end
  end

  // Slot counter and serial outputs, updated only on bck falls; stopping aborts the frame.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      slot     <= SLOT_W'(FRAME_BITS - 1);
      frame_sh <= '0;
      i2s_ws   <= 1'b0;
      i2s_d0   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (bck_fall) begin
        slot   <= slot_nxt;
        i2s_ws <= ws_for_slot(slot_nxt);
        if (frame_start) begin
          i2s_d0   <= frame_src[FRAME_BITS-1];
          frame_sh <= {frame_src[FRAME_BITS-2:0], 1'b0};
          underrun <= !hold_full;
        end else begin
          i2s_d0   <= frame_sh[FRAME_BITS-1];
          frame_sh <= {frame_sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: time-based behavioural model compared every
// cycle, plus directed scenarios with hand-computed frame contents.
module tb_i2s_tx_serializer;

  localparam int DW        = 16;
  localparam int BH        = 2;
  localparam int FALL_P    = 2 * BH;
  localparam int FRAME_CLK = 64 * FALL_P;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] left_in = '0;
  logic [DW-1:0] right_in = '0;
  logic          sample_ready;
  logic          i2s_bck;
  logic          i2s_ws;
  logic          i2s_d0;
  logic          underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.DW(DW), .BCK_HALF(BH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .left_in     (left_in),
    .right_in    (right_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bck     (i2s_bck),
    .i2s_ws      (i2s_ws),
    .i2s_d0      (i2s_d0),
    .underrun    (underrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: everything derived from clk edges elapsed since enable.
  int            m_t;
  int            m_s;
  bit            m_hs;
  bit            m_live = 0;
  logic          m_hfull;
  logic [DW-1:0] m_hl, m_hr, m_fl, m_fr;
  logic          e_bck, e_ws, e_d0, e_ur, e_rdy;

  always @(posedge clk) begin
    m_hs = sample_valid && !m_hfull;
    if (reset) begin
      m_live = 1; m_t = 0; m_hfull = 0;
      m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
      e_bck = 0; e_ws = 0; e_d0 = 0; e_ur = 0; e_rdy = 1;
    end else begin
      if (!enable) begin
        m_t = 0; m_fl = '0; m_fr = '0;
        e_bck = 0; e_ws = 0; e_d0 = 0; e_ur = 0;
      end else begin
        m_t++;
        e_bck = ((m_t / BH) % 2) == 1;
        e_ur  = 0;
        if (m_t % FALL_P == 0) begin
          m_s = (m_t / FALL_P - 1) % 64;
          if (m_s == 0) begin
            if (m_hfull) begin
              m_fl = m_hl; m_fr = m_hr; m_hfull = 0;
            end else begin
              m_fl = '0; m_fr = '0; e_ur = 1;
            end
          end
          e_ws = (m_s >= 31) && (m_s <= 62);
          if (m_s < DW) e_d0 = m_fl[DW-1-m_s];
          else if (m_s >= 32 && m_s < 32 + DW) e_d0 = m_fr[DW-1-(m_s-32)];
          else e_d0 = 0;
        end
      end
      if (m_hs) begin
        m_hfull = 1; m_hl = left_in; m_hr = right_in;
      end
      e_rdy = !m_hfull;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("bck", i2s_bck, e_bck);
      check("ws", i2s_ws, e_ws);
      check("d0", i2s_d0, e_d0);
      check("underrun", underrun, e_ur);
      check("ready", sample_ready, e_rdy);
    end
  end

  // Frame capture: sample d0/ws at each bck rise; first rise after enable precedes slot 0.
  logic        en_q = 1'b0;
  logic        prev_bck = 1'b0;
  int          rises = 0;
  logic [63:0] cw, ww;
  logic [63:0] frames[$];
  logic [63:0] wsw[$];

  always @(posedge clk) en_q <= enable && !reset;

  always @(negedge clk) begin
    if (!en_q) begin
      rises = 0; cw = '0; ww = '0;
    end else if (i2s_bck && !prev_bck) begin
      rises++;
      if (rises >= 2) begin
        cw = {cw[62:0], i2s_d0};
        ww = {ww[62:0], i2s_ws};
        if ((rises - 1) % 64 == 0) begin
          frames.push_back(cw);
          wsw.push_back(ww);
        end
      end
    end
    prev_bck = i2s_bck;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; enable = 0; sample_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    frames.delete();
    wsw.delete();
  endtask

  task automatic wait_frames(input int n);
    int g = 0;
    while (frames.size() < n && g < FRAME_CLK * (n + 2)) begin
      @(negedge clk); g++;
    end
    if (frames.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frames: got %0d frames expected %0d", frames.size(), n);
    end
  endtask

  task automatic wait_underrun();
    int g = 0;
    while (!underrun && g < FRAME_CLK + 16) begin
      @(negedge clk); g++;
    end
    if (!underrun) begin
      n_checks++; n_fail++;
      $display("FAIL wait_underrun: got no pulse expected one");
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input bit keep);
    int g = 0;
    sample_valid = 1; left_in = l; right_in = r;
    while (!sample_ready && g < 2 * FRAME_CLK) begin
      @(negedge clk); g++;
    end
    if (!sample_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push: got ready=0 expected ready=1");
    end
    @(negedge clk);
    if (!keep) sample_valid = 0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int p;
    int c0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bck", i2s_bck, 0);
    check("rst_ws", i2s_ws, 0);
    check("rst_d0", i2s_d0, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", sample_ready, 1);
    reset = 0;
    frames.delete(); wsw.delete();

    // Basic frame, underrun on frame 1, ws timing and bck period
    enable = 1;
    cnt = 0;
    while (!underrun && cnt < 50) begin
      @(negedge clk); cnt++;
    end
    check("first_underrun_clk", cnt, 4);
    p = 0;
    while (i2s_bck && p < 20) begin @(negedge clk); p++; end
    while (!i2s_bck && p < 20) begin @(negedge clk); p++; end
    p = 0;
    while (i2s_bck && p < 20) begin @(negedge clk); p++; end
    while (!i2s_bck && p < 20) begin @(negedge clk); p++; end
    check("bck_period", p, 4);
    push(16'hA5C3, 16'h0F0F, 0);
    wait_frames(3);
    check("f1_zero", frames[0], 64'h0);
    check("f2_data", frames[1], 64'hA5C3_0000_0F0F_0000);
    check("f3_zero", frames[2], 64'h0);
    check("ws_word_f1", wsw[0], 64'h0000_0001_FFFF_FFFE);
    check("ws_word_f2", wsw[1], 64'h0000_0001_FFFF_FFFE);

    // Backpressure with valid held high
    do_reset();
    enable = 1;
    wait_underrun();
    push(16'h1234, 16'h8001, 1);
    check("ready_after_accept", sample_ready, 0);
    push(16'h7FFF, 16'hFFFF, 1);
    push(16'h0001, 16'h8000, 0);
    wait_frames(4);
    check("bp_f0", frames[0], 64'h0);
    check("bp_a", frames[1], pk(16'h1234, 16'h8001));
    check("bp_b", frames[2], pk(16'h7FFF, 16'hFFFF));
    check("bp_c", frames[3], pk(16'h0001, 16'h8000));

    // Push exactly on a frame-boundary clk with holding empty
    do_reset();
    enable = 1;
    repeat (259) @(negedge clk);
    sample_valid = 1; left_in = 16'hC3C3; right_in = 16'h5A5A;
    @(negedge clk);
    sample_valid = 0;
    check("boundary_underrun", underrun, 1);
    check("boundary_accept", sample_ready, 0);
    wait_frames(3);
    check("boundary_f2_zero", frames[1], 64'h0);
    check("boundary_f3", frames[2], pk(16'hC3C3, 16'h5A5A));

    // Disable at s=40 with a pending pair, then re-enable
    do_reset();
    enable = 1;
    c0 = cyc;
    wait_underrun();
    push(16'hF00F, 16'h00FF, 0);
    push(16'h8421, 16'h1248, 0);
    wait_cyc(c0 + 420);
    check("s40_ws", i2s_ws, 1);
    check("s40_d0", i2s_d0, 1);
    enable = 0;
    @(negedge clk);
    check("dis_bck", i2s_bck, 0);
    check("dis_ws", i2s_ws, 0);
    check("dis_d0", i2s_d0, 0);
    repeat (20) @(negedge clk);
    check("hold_retained", sample_ready, 0);
    frames.delete(); wsw.delete();
    enable = 1;
    wait_frames(1);
    check("reenable_pending", frames[0], pk(16'h8421, 16'h1248));

    // Reset mid-frame with holding full
    do_reset();
    enable = 1;
    wait_underrun();
    push(16'h1111, 16'h2222, 0);
    push(16'h3333, 16'h4444, 0);
    repeat (100) @(negedge clk);
    check("pre_rst_full", sample_ready, 0);
    reset = 1;
    @(negedge clk);
    check("mid_rst_bck", i2s_bck, 0);
    check("mid_rst_ws", i2s_ws, 0);
    check("mid_rst_d0", i2s_d0, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_ready", sample_ready, 1);
    reset = 0;
    frames.delete(); wsw.delete();
    wait_frames(2);
    check("post_rst_f1", frames[0], 64'h0);
    check("post_rst_f2", frames[1], 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
